// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared definitions for the pipeline hazard controller
//
// Contents:
//   REG_ADDR_SIZE  register-file address width
//   state_e        controller FSM states (INIT=0, RUN=1, MEM_WAIT=2)
//   NOP_INSTR      instruction loaded into IF/ID when it is flushed (addi x0,x0,0)
//   ctrl_t         bundle of the five pipeline sequencing controls
//   CTRL_*         control patterns for each controller action
package hazard_ctrl_pkg;

    localparam int REG_ADDR_SIZE = 5;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic pc_wr;
        logic if_id_wr;
        logic if_id_flush;
        logic id_ex_bubble;
        logic ex_mem_wr;
    } ctrl_t;

    // Field order: pc_wr, if_id_wr, if_id_flush, id_ex_bubble, ex_mem_wr
    localparam ctrl_t CTRL_INIT   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam ctrl_t CTRL_NORMAL = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
//
// Ports:
//   i_clk  clock, state on rising edge
//   i_rst  synchronous active-high reset, zeroes the count
//   i_clr  synchronous clear, wins over i_inc
//   i_inc  count one event this cycle
//   o_cnt  current count, holds at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            cnt_q <= '0;
        end else if (i_inc && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline hazard controller (load-use stall, branch flush, memory freeze)
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_id_rs1/rs2, i_id_use_rs1/2  source registers of the decode instruction
//   i_ex_rd, i_ex_mem_read        destination / load flag of the EX instruction
//   i_ex_branch_taken             branch in EX resolved taken
//   i_mem_busy                    data memory not ready
//   i_cnt_clr                     clear debug counters
//   o_pc_wr, o_if_id_wr           PC / IF-ID load enables
//   o_if_id_flush, o_id_ex_bubble NOP insertion into IF/ID and ID/EX
//   o_ex_mem_wr                   EX/MEM and MEM/WB load enable
//   o_stall_cnt, o_flush_cnt      saturating stall-cycle / branch-flush counters
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_SIZE = hazard_ctrl_pkg::REG_ADDR_SIZE,
    parameter int CNT_W         = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [REG_ADDR_SIZE-1:0] i_id_rs1,
    input  logic [REG_ADDR_SIZE-1:0] i_id_rs2,
    input  logic                     i_id_use_rs1,
    input  logic                     i_id_use_rs2,
    input  logic [REG_ADDR_SIZE-1:0] i_ex_rd,
    input  logic                     i_ex_mem_read,
    input  logic                     i_ex_branch_taken,
    input  logic                     i_mem_busy,
    input  logic                     i_cnt_clr,
    output logic                     o_pc_wr,
    output logic                     o_if_id_wr,
    output logic                     o_if_id_flush,
    output logic                     o_id_ex_bubble,
    output logic                     o_ex_mem_wr,
    output logic [CNT_W-1:0]         o_stall_cnt,
    output logic [CNT_W-1:0]         o_flush_cnt
);

    state_e state_q, state_d;
    ctrl_t  ctrl, run_ctrl;
    logic   load_use;
    logic   flush_evt;
    logic   stall_evt;

    // x0 is hardwired to zero, so a load targeting it never produces a hazard.
    assign load_use = i_ex_mem_read && (i_ex_rd != '0) &&
                      ((i_id_use_rs1 && (i_id_rs1 == i_ex_rd)) ||
                       (i_id_use_rs2 && (i_id_rs2 == i_ex_rd)));

    // Shared by RUN and the exit cycle of MEM_WAIT, so a branch or hazard
    // frozen in EX during a memory wait is serviced when the wait ends.
    always_comb begin
        run_ctrl = CTRL_NORMAL;
        if (i_ex_branch_taken) begin
            run_ctrl = CTRL_FLUSH;
        end else if (load_use) begin
            run_ctrl = CTRL_STALL;
        end
    end

    always_comb begin
        state_d   = state_q;
        ctrl      = CTRL_FREEZE;
        flush_evt = 1'b0;
        case (state_q)
            INIT: begin
                ctrl    = CTRL_INIT;
                state_d = RUN;
            end
            RUN: begin
                if (i_mem_busy) begin
                    state_d = MEM_WAIT;
                end else begin
                    ctrl      = run_ctrl;
                    flush_evt = i_ex_branch_taken;
                end
            end
            MEM_WAIT: begin
                if (!i_mem_busy) begin
                    ctrl      = run_ctrl;
                    flush_evt = i_ex_branch_taken;
                    state_d   = RUN;
                end
            end
            default: begin
                ctrl    = CTRL_INIT;
                state_d = RUN;
            end
        endcase
        // Outputs during reset look like INIT so the pipeline is scrubbed
        // on the same edge that resets the controller.
        if (i_rst) begin
            ctrl      = CTRL_INIT;
            flush_evt = 1'b0;
            state_d   = INIT;
        end
    end

    // INIT holds the PC by design; it is not counted as a stall.
    assign stall_evt = !ctrl.pc_wr && (state_q != INIT) && !i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    assign o_pc_wr        = ctrl.pc_wr;
    assign o_if_id_wr     = ctrl.if_id_wr;
    assign o_if_id_flush  = ctrl.if_id_flush;
    assign o_id_ex_bubble = ctrl.id_ex_bubble;
    assign o_ex_mem_wr    = ctrl.ex_mem_wr;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_cnt_clr),
        .i_inc (stall_evt),
        .o_cnt (o_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_cnt_clr),
        .i_inc (flush_evt),
        .o_cnt (o_flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int RW    = 5;
    localparam int CW    = 4;
    localparam int SAT   = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] id_rs1, id_rs2, ex_rd;
    logic          use_rs1, use_rs2, mem_read, br, busy, clr;
    logic          pc_wr, if_id_wr, if_id_flush, id_ex_bubble, ex_mem_wr;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_SIZE(RW), .CNT_W(CW)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_id_rs1          (id_rs1),
        .i_id_rs2          (id_rs2),
        .i_id_use_rs1      (use_rs1),
        .i_id_use_rs2      (use_rs2),
        .i_ex_rd           (ex_rd),
        .i_ex_mem_read     (mem_read),
        .i_ex_branch_taken (br),
        .i_mem_busy        (busy),
        .i_cnt_clr         (clr),
        .o_pc_wr           (pc_wr),
        .o_if_id_wr        (if_id_wr),
        .o_if_id_flush     (if_id_flush),
        .o_id_ex_bubble    (id_ex_bubble),
        .o_ex_mem_wr       (ex_mem_wr),
        .o_stall_cnt       (stall_cnt),
        .o_flush_cnt       (flush_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the controller outputs depend only on whether this is
    // the first cycle after reset plus the current inputs; RUN and MEM_WAIT
    // are indistinguishable on the outputs.
    bit       m_first;        // current cycle is the post-reset INIT cycle
    int       m_stall;
    int       m_flush;
    bit [4:0] exp_ctrl;       // {pc_wr, if_id_wr, if_id_flush, id_ex_bubble, ex_mem_wr}
    bit       exp_flush_evt;

    wire [4:0] act_ctrl = {pc_wr, if_id_wr, if_id_flush, id_ex_bubble, ex_mem_wr};

    function automatic bit hazard_ref();
        if (!mem_read || ex_rd == 0) return 1'b0;
        return (use_rs1 && id_rs1 == ex_rd) || (use_rs2 && id_rs2 == ex_rd);
    endfunction

    task automatic drive(input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                         input logic u1, input logic u2, input logic [RW-1:0] rd,
                         input logic mr, input logic b, input logic bz,
                         input logic c, input logic r);
        id_rs1 = rs1; id_rs2 = rs2; use_rs1 = u1; use_rs2 = u2; ex_rd = rd;
        mem_read = mr; br = b; busy = bz; clr = c; rst = r;
        exp_flush_evt = 1'b0;
        if (r || m_first)       exp_ctrl = 5'b01111;
        else if (bz)            exp_ctrl = 5'b00000;
        else if (b) begin       exp_ctrl = 5'b11111; exp_flush_evt = 1'b1; end
        else if (hazard_ref())  exp_ctrl = 5'b00011;
        else                    exp_ctrl = 5'b11001;
        #1;
    endtask

    task automatic idle_inputs();
        drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst || clr) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (!exp_ctrl[4] && !m_first && m_stall < SAT) m_stall++;
            if (exp_flush_evt && m_flush < SAT) m_flush++;
        end
        m_first = rst;
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (act_ctrl !== 5'b01111) $display("FAIL reset_outputs: got %b want 01111", act_ctrl);
        else n_pass++;
        tick();
        idle_inputs();
        n_checks++;
        if (act_ctrl !== 5'b01111) $display("FAIL init_cycle: got %b want 01111", act_ctrl);
        else n_pass++;
        tick();
        idle_inputs();
        n_checks++;
        if (act_ctrl !== 5'b11001) $display("FAIL first_run: got %b want 11001", act_ctrl);
        else n_pass++;
        n_checks++;
        if (stall_cnt !== 0 || flush_cnt !== 0)
            $display("FAIL counters_after_reset: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        else n_pass++;
        tick();
    endtask

    task automatic test_load_use();
        drive(5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (act_ctrl !== 5'b00011) $display("FAIL load_use_stall: got %b want 00011", act_ctrl);
        else n_pass++;
        tick();
        idle_inputs();
        n_checks++;
        if (stall_cnt !== 1) $display("FAIL load_use_count: got %0d want 1", stall_cnt);
        else n_pass++;
        n_checks++;
        if (act_ctrl !== 5'b11001) $display("FAIL after_stall: got %b want 11001", act_ctrl);
        else n_pass++;
        tick();
        drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (act_ctrl !== 5'b11001) $display("FAIL x0_no_hazard: got %b want 11001", act_ctrl);
        else n_pass++;
        tick();
        drive(5'd3, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (act_ctrl !== 5'b11001) $display("FAIL unused_rs2: got %b want 11001", act_ctrl);
        else n_pass++;
        tick();
        idle_inputs();
        n_checks++;
        if (stall_cnt !== 1) $display("FAIL no_extra_stall: got %0d want 1", stall_cnt);
        else n_pass++;
        tick();
    endtask

    task automatic test_branch_vs_hazard();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (act_ctrl !== 5'b11111) $display("FAIL branch_wins: got %b want 11111", act_ctrl);
        else n_pass++;
        tick();
        idle_inputs();
        n_checks++;
        if (flush_cnt !== 1 || stall_cnt !== 0)
            $display("FAIL branch_counts: got flush %0d stall %0d want 1 0", flush_cnt, stall_cnt);
        else n_pass++;
        tick();
    endtask

    task automatic test_mem_wait();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (act_ctrl !== 5'b00000) $display("FAIL mem_freeze_%0d: got %b want 00000", i, act_ctrl);
            else n_pass++;
            tick();
        end
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (act_ctrl !== 5'b11111) $display("FAIL flush_on_exit: got %b want 11111", act_ctrl);
        else n_pass++;
        tick();
        idle_inputs();
        n_checks++;
        if (stall_cnt !== 3 || flush_cnt !== 1)
            $display("FAIL mem_wait_counts: got stall %0d flush %0d want 3 1", stall_cnt, flush_cnt);
        else n_pass++;
        tick();
    endtask

    task automatic test_saturation();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle_inputs();
        n_checks++;
        if (stall_cnt !== 4'd15) $display("FAIL stall_saturate: got %0d want 15", stall_cnt);
        else n_pass++;
        drive(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        idle_inputs();
        n_checks++;
        if (stall_cnt !== 0) $display("FAIL clr_priority: got %0d want 0", stall_cnt);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_in_wait();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (act_ctrl !== 5'b01111) $display("FAIL rst_in_wait_out: got %b want 01111", act_ctrl);
        else n_pass++;
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (act_ctrl !== 5'b01111) $display("FAIL init_despite_busy: got %b want 01111", act_ctrl);
        else n_pass++;
        n_checks++;
        if (stall_cnt !== 0 || flush_cnt !== 0)
            $display("FAIL rst_in_wait_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        else n_pass++;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            drive(RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), RW'($urandom_range(0, 3)),
                  1'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 40) == 0), ($urandom_range(0, 60) == 0));
            n_checks++;
            if (act_ctrl !== exp_ctrl) begin
                if (errs < 10) $display("FAIL rand_ctrl[%0d]: got %b want %b", i, act_ctrl, exp_ctrl);
                errs++;
            end else n_pass++;
            tick();
            n_checks++;
            if (stall_cnt !== CW'(m_stall) || flush_cnt !== CW'(m_flush)) begin
                if (errs < 10)
                    $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d",
                             i, stall_cnt, flush_cnt, m_stall, m_flush);
                errs++;
            end else n_pass++;
        end
    endtask

    initial begin
        m_first = 1'b0;
        m_stall = 0;
        m_flush = 0;
        @(negedge clk);
        test_reset();
        test_load_use();
        test_branch_vs_hazard();
        test_mem_wait();
        test_saturation();
        test_reset_in_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
